// File: rtl/ntt_defines_pkg.sv
// Shared constants and types for the NTT masked-multiplier scheduling logic.
// Contents:
//   MASKED_MULT_LATENCY  issue-to-result latency of the two-share BFU multiplier
//   mult_sched_state_e   scheduler flush/drain state
//   mult_sched_entry_t   {vld, id, tag} record carried alongside the multiplier pipeline
package ntt_defines_pkg;

  // mult + A2B + reduction + B2A + output reg
  localparam int unsigned MASKED_MULT_LATENCY = 210;

  localparam int unsigned SCHED_NUM_REQ = 2;
  localparam int unsigned SCHED_ID_W    = (SCHED_NUM_REQ > 1) ? $clog2(SCHED_NUM_REQ) : 1;
  localparam int unsigned SCHED_TAG_W   = 8;

  typedef enum logic [1:0] {
    SCHED_ACTIVE = 2'd0,
    SCHED_DRAIN  = 2'd1,
    SCHED_DONE   = 2'd2,
    SCHED_HOLD   = 2'd3
  } mult_sched_state_e;

  typedef struct packed {
    logic                   vld;
    logic [SCHED_ID_W-1:0]  id;
    logic [SCHED_TAG_W-1:0] tag;
  } mult_sched_entry_t;

endpackage

// File: rtl/ntt_rr_arbiter.sv
// Round-robin arbiter for a shared resource.
// Ports:
//   clk, reset_n  clock, async active-low reset
//   clear         sync return of the search pointer to requester 0
//   req           request vector
//   advance       a grant was taken this cycle; pointer moves past the winner
//   grant         one-hot winner (zero when no request)
//   index         binary index of the winner (zero when no request)
//   any           at least one request is present
module ntt_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic [NUM_REQ-1:0]  req,
  input  logic                advance,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_W-1:0]     index,
  output logic                any
);

  // Search start position: one past the last granted requester.
  logic [ID_W-1:0]    ptr_q;
  logic [NUM_REQ-1:0] rot;
  logic [ID_W-1:0]    off;
  logic [ID_W:0]      sum;

  assign any = |req;

  always_comb begin
    // Rotate so that bit 0 is the requester at the search start.
    rot = NUM_REQ'({req, req} >> ptr_q);
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = ID_W'(i);
    end
    sum = {1'b0, ptr_q} + {1'b0, off};
    if (sum >= (ID_W + 1)'(NUM_REQ)) sum = sum - (ID_W + 1)'(NUM_REQ);
    index = any ? sum[ID_W-1:0] : '0;
    grant = '0;
    for (int c = 0; c < NUM_REQ; c++) begin
      grant[c] = any && (index == ID_W'(c));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (clear) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (index == ID_W'(NUM_REQ - 1)) ? '0 : index + 1'b1;
    end
  end

endmodule

// File: rtl/ntt_masked_mult_sched.sv
// Issue scheduler and tag tracker for the fixed-latency two-share masked BFU multiplier.
// Ports:
//   clk, reset_n           clock, async active-low reset
//   zeroize                sync clear of all state; forces every output to 0
//   req_valid/req_tag      per-requester operand-ready and tag (tag sampled on grant)
//   req_ready              one-hot grant, combinational
//   rnd_valid/rnd_consume  masking randomness fresh / advance entropy source on issue
//   mult_issue/mult_sel    operand strobe and operand mux select to the multiplier
//   flush_req/flush_done   stop granting and drain; one-cycle pulse when drained
//   res_valid/res_id/res_tag  retiring op, exactly LATENCY clks after its issue
//   inflight, busy         outstanding count; activity indication
module ntt_masked_mult_sched
  import ntt_defines_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned TAG_W        = 8,
  parameter int unsigned LATENCY      = MASKED_MULT_LATENCY,
  parameter int unsigned MAX_INFLIGHT = 210,
  localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     zeroize,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     rnd_valid,
  output logic                     rnd_consume,
  output logic                     mult_issue,
  output logic [ID_W-1:0]          mult_sel,
  input  logic                     flush_req,
  output logic                     flush_done,
  output logic                     res_valid,
  output logic [ID_W-1:0]          res_id,
  output logic [TAG_W-1:0]         res_tag,
  output logic [CNT_W-1:0]         inflight,
  output logic                     busy
);

  typedef struct packed {
    logic             vld;
    logic [ID_W-1:0]  id;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t            pipe_q [LATENCY];
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  mult_sched_state_e state_q, state_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0]    arb_index;
  logic               arb_any;
  logic [TAG_W-1:0]   sel_tag;
  logic               live;
  logic               issue;
  logic               retire;

  // Reset is folded in so nothing can be granted while reset is asserted.
  assign live   = reset_n && !zeroize;
  assign retire = pipe_q[LATENCY-1].vld;
  assign issue  = live && (state_q == SCHED_ACTIVE) && rnd_valid && arb_any && !flush_req &&
                  (inflight_q < CNT_W'(MAX_INFLIGHT));

  ntt_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (zeroize),
    .req     (req_valid),
    .advance (issue),
    .grant   (arb_grant),
    .index   (arb_index),
    .any     (arb_any)
  );

  always_comb begin
    sel_tag = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_index == ID_W'(i)) sel_tag = req_tag[i*TAG_W +: TAG_W];
    end
  end

  assign req_ready   = issue ? arb_grant : '0;
  assign mult_issue  = issue;
  assign rnd_consume = issue;
  assign mult_sel    = issue ? arb_index : '0;

  // Tag delay line mirrors the non-stallable multiplier: shifts every cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else if (zeroize) begin
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= issue ? entry_t'{vld: 1'b1, id: arb_index, tag: sel_tag} : '0;
      for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (issue && !retire) inflight_d = inflight_q + 1'b1;
    else if (!issue && retire) inflight_d = inflight_q - 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SCHED_ACTIVE: if (flush_req) state_d = SCHED_DRAIN;
      // No issues in DRAIN, so a retire of the last op empties the pipe this cycle.
      SCHED_DRAIN:  if (inflight_q == CNT_W'(retire)) state_d = SCHED_DONE;
      SCHED_DONE:   state_d = flush_req ? SCHED_HOLD : SCHED_ACTIVE;
      SCHED_HOLD:   if (!flush_req) state_d = SCHED_ACTIVE;
      default:      state_d = SCHED_ACTIVE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q <= '0;
      state_q    <= SCHED_ACTIVE;
    end else if (zeroize) begin
      inflight_q <= '0;
      state_q    <= SCHED_ACTIVE;
    end else begin
      inflight_q <= inflight_d;
      state_q    <= state_d;
    end
  end

  assign res_valid  = live && pipe_q[LATENCY-1].vld;
  assign res_id     = res_valid ? pipe_q[LATENCY-1].id : '0;
  assign res_tag    = res_valid ? pipe_q[LATENCY-1].tag : '0;
  assign inflight   = live ? inflight_q : '0;
  assign flush_done = live && (state_q == SCHED_DONE);
  assign busy       = live && ((inflight_q != '0) || (state_q != SCHED_ACTIVE));

endmodule

// File: tb/tb_ntt_masked_mult_sched.sv
// Self-checking bench for ntt_masked_mult_sched: an operation-level model (queue of outstanding
// ops with due cycles) is checked against the DUT every cycle, plus literal pin-down checks.
module tb_ntt_masked_mult_sched;

  localparam int NR   = 2;
  localparam int TW   = 8;
  localparam int LAT  = 210;
  localparam int MAXI = 6;
  localparam int IDW  = 1;
  localparam int CW   = 3;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             zeroize = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*TW-1:0] req_tag = '0;
  logic [NR-1:0]    req_ready;
  logic             rnd_valid = 1'b0;
  logic             rnd_consume;
  logic             mult_issue;
  logic [IDW-1:0]   mult_sel;
  logic             flush_req = 1'b0;
  logic             flush_done;
  logic             res_valid;
  logic [IDW-1:0]   res_id;
  logic [TW-1:0]    res_tag;
  logic [CW-1:0]    inflight;
  logic             busy;

  ntt_masked_mult_sched #(
    .NUM_REQ      (NR),
    .TAG_W        (TW),
    .LATENCY      (LAT),
    .MAX_INFLIGHT (MAXI)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .zeroize     (zeroize),
    .req_valid   (req_valid),
    .req_tag     (req_tag),
    .req_ready   (req_ready),
    .rnd_valid   (rnd_valid),
    .rnd_consume (rnd_consume),
    .mult_issue  (mult_issue),
    .mult_sel    (mult_sel),
    .flush_req   (flush_req),
    .flush_done  (flush_done),
    .res_valid   (res_valid),
    .res_id      (res_id),
    .res_tag     (res_tag),
    .inflight    (inflight),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int id;
    int tag;
  } op_t;

  op_t q[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  mode = 0;  // 0 active, 1 drain, 2 done, 3 hold
  int  ptr = 0;   // requester searched first

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  // Model and per-cycle comparison
  always @(negedge clk) begin : cmp
    int  retire_m, can, gid, c, e_ready, e_rid, e_rtag;
    logic [NR*TW-1:0] sh;
    if (!reset_n || zeroize) begin
      chk("rst_req_ready", int'(req_ready), 0);
      chk("rst_mult_issue", int'(mult_issue), 0);
      chk("rst_res_valid", int'(res_valid), 0);
      chk("rst_inflight", int'(inflight), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_flush_done", int'(flush_done), 0);
      q.delete();
      mode = 0;
      ptr = 0;
    end else begin
      retire_m = (q.size() > 0 && q[0].due == cyc) ? 1 : 0;
      can = (mode == 0 && rnd_valid && q.size() < MAXI && req_valid != 0 && !flush_req) ? 1 : 0;
      gid = -1;
      if (can != 0) begin
        for (int k = 0; k < NR; k++) begin
          c = (ptr + k) % NR;
          if (gid < 0 && req_valid[c]) gid = c;
        end
      end
      e_ready = (can != 0) ? (1 << gid) : 0;
      e_rid   = (retire_m != 0) ? q[0].id : 0;
      e_rtag  = (retire_m != 0) ? q[0].tag : 0;
      chk("req_ready", int'(req_ready), e_ready);
      chk("mult_issue", int'(mult_issue), can);
      chk("rnd_consume", int'(rnd_consume), can);
      chk("mult_sel", int'(mult_sel), (can != 0) ? gid : 0);
      chk("res_valid", int'(res_valid), retire_m);
      chk("res_id", int'(res_id), e_rid);
      chk("res_tag", int'(res_tag), e_rtag);
      chk("inflight", int'(inflight), q.size());
      chk("busy", int'(busy), (q.size() != 0 || mode != 0) ? 1 : 0);
      chk("flush_done", int'(flush_done), (mode == 2) ? 1 : 0);
      if (retire_m != 0) void'(q.pop_front());
      if (can != 0) begin
        sh = req_tag >> (gid * TW);
        q.push_back('{due: cyc + LAT, id: gid, tag: int'(sh[TW-1:0])});
        ptr = (gid + 1) % NR;
      end
      case (mode)
        0: if (flush_req) mode = 1;
        1: if (q.size() == 0) mode = 2;
        2: mode = flush_req ? 3 : 0;
        default: if (!flush_req) mode = 0;
      endcase
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) step();
  endtask

  initial begin : stim
    logic [3:0] pat;
    int nissue, done_at, fl_cnt;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    wait_cycles(2);

    // Fairness right after reset: search starts at requester 0
    req_valid = 2'b11;
    req_tag   = 16'h2211;
    rnd_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("fair_grant", int'(req_ready), (k % 2 == 0) ? 1 : 2);
      step();
    end
    req_valid = '0;
    repeat (205) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      chk("fair_res_valid", int'(res_valid), 1);
      chk("fair_res_id", int'(res_id), k % 2);
      chk("fair_res_tag", int'(res_tag), (k % 2 == 0) ? 'h11 : 'h22);
      @(negedge clk);
    end

    // Single op, latency pin
    step();
    req_valid = 2'b01;
    req_tag   = 16'h005A;
    @(negedge clk);
    chk("single_ready", int'(req_ready), 1);
    chk("single_issue", int'(mult_issue), 1);
    step();
    req_valid = '0;
    repeat (209) @(negedge clk);
    chk("single_early", int'(res_valid), 0);
    @(negedge clk);
    chk("single_res_valid", int'(res_valid), 1);
    chk("single_res_tag", int'(res_tag), 'h5A);
    chk("single_res_id", int'(res_id), 0);
    @(negedge clk);
    chk("single_inflight0", int'(inflight), 0);

    // Entropy gating
    step();
    pat = 4'b1001;
    req_valid = 2'b01;
    req_tag   = 16'h0033;
    for (int k = 0; k < 4; k++) begin
      rnd_valid = pat[k];
      @(negedge clk);
      chk("ent_consume", int'(rnd_consume), int'(pat[k]));
      chk("ent_ready", int'(req_ready), int'(pat[k]));
      step();
    end
    req_valid = '0;
    rnd_valid = 1'b1;
    wait_cycles(215);

    // Cap: continuous requests stop at MAXI outstanding
    req_valid = 2'b11;
    req_tag   = 16'hB4A3;
    nissue = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mult_issue) nissue++;
      step();
    end
    chk("cap_issues", nissue, MAXI);
    @(negedge clk);
    chk("cap_inflight", int'(inflight), MAXI);
    step();
    req_valid = '0;
    wait_cycles(215);

    // Flush with empty pipe: done two clks later, then HOLD
    flush_req = 1'b1;
    @(negedge clk);
    chk("flush0_done_t0", int'(flush_done), 0);
    @(negedge clk);
    chk("flush0_done_t1", int'(flush_done), 0);
    @(negedge clk);
    chk("flush0_done_t2", int'(flush_done), 1);
    step();
    req_valid = 2'b01;
    @(negedge clk);
    chk("hold_no_grant", int'(req_ready), 0);
    chk("hold_no_repulse", int'(flush_done), 0);
    step();
    flush_req = 1'b0;
    @(negedge clk);
    chk("hold_exit_cycle", int'(req_ready), 0);
    @(negedge clk);
    chk("resume_grant", int'(req_ready), 1);
    step();
    req_valid = '0;
    wait_cycles(215);

    // Flush with two ops in flight
    req_valid = 2'b01;
    wait_cycles(2);
    flush_req = 1'b1;
    done_at = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (flush_done) begin
        done_at = n;
        break;
      end
    end
    chk("flush_latency", done_at, 210);
    step();
    flush_req = 1'b0;
    req_valid = '0;
    wait_cycles(5);

    // Zeroize with ops outstanding
    req_valid = 2'b11;
    wait_cycles(5);
    req_valid = '0;
    wait_cycles(95);
    zeroize = 1'b1;
    step();
    zeroize = 1'b0;
    req_valid = 2'b10;
    req_tag   = 16'h7700;
    @(negedge clk);
    chk("zero_new_ready", int'(req_ready), 2);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("zero_inflight", int'(inflight), 1);
    wait_cycles(215);

    // Randomized traffic
    fl_cnt = 0;
    for (int i = 0; i < 5000; i++) begin
      req_valid = NR'($urandom_range(0, 3));
      req_tag   = (NR * TW)'($urandom);
      rnd_valid = ($urandom_range(0, 9) < 7);
      if (fl_cnt > 0) begin
        fl_cnt--;
        flush_req = 1'b1;
      end else begin
        flush_req = 1'b0;
        if ($urandom_range(0, 399) == 0) fl_cnt = $urandom_range(1, 400);
      end
      zeroize = ($urandom_range(0, 699) == 0);
      if (i == 2500) reset_n = 1'b0;
      if (i == 2502) reset_n = 1'b1;
      step();
    end
    req_valid = '0;
    flush_req = 1'b0;
    zeroize   = 1'b0;
    wait_cycles(250);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
